// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS core front end.
package mips_pkg;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'b00,
    NPC_BR  = 2'b01,
    NPC_J   = 2'b10,
    NPC_JR  = 2'b11
  } npc_op_e;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StFetch = 2'b01,
    StHold  = 2'b10
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC selection: sequential, branch, jump and register-indirect.
module npc_calc
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  npc_op,
  input  logic        br_taken,
  input  logic [31:0] imm_ext,
  input  logic [25:0] j_index,
  input  logic [31:0] jr_target,
  output logic [31:0] npc
);

  logic [31:0] pc_plus4;

  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    npc = pc_plus4;
    unique case (npc_op)
      NPC_SEQ: npc = pc_plus4;
      NPC_BR:  npc = br_taken ? (pc_plus4 + imm_ext) : pc_plus4;
      NPC_J:   npc = {pc_plus4[31:28], j_index, 2'b00};
      NPC_JR:  npc = {jr_target[31:2], 2'b00};
      default: npc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: PC register, req/ack fetch FSM and held instruction for decode.
module ifu_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [15:0] imm16,
  output logic [31:0] pc,
  input  logic [1:0]  npc_op,
  input  logic        br_taken,
  input  logic [31:0] imm_ext,
  input  logic [25:0] j_index,
  input  logic [31:0] jr_target,
  output logic        misalign
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic         misalign_q, misalign_d;
  logic [31:0]  npc;
  logic         capture;
  logic         retire;

  npc_calc u_npc_calc (
    .pc        (pc_q),
    .npc_op    (npc_op),
    .br_taken  (br_taken),
    .imm_ext   (imm_ext),
    .j_index   (j_index),
    .jr_target (jr_target),
    .npc       (npc)
  );

  assign capture = (state_q == StFetch) && imem_ack;
  assign retire  = (state_q == StHold) && instr_ready;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    misalign_d = 1'b0;
    unique case (state_q)
      StIdle:  state_d = StFetch;
      StFetch: begin
        if (capture) begin
          state_d = StHold;
          instr_d = imem_rdata;
        end
      end
      StHold: begin
        if (retire) begin
          state_d    = StFetch;
          pc_d       = npc;
          // Registered so the flag lines up with the cycle after the redirect.
          misalign_d = (npc_op == NPC_JR) && (jr_target[1:0] != 2'b00);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      instr_q    <= 32'h0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      misalign_q <= misalign_d;
    end
  end

  assign imem_req    = (state_q == StFetch);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == StHold);
  assign instr       = instr_q;
  assign imm16       = instr_q[15:0];
  assign pc          = pc_q;
  assign misalign    = misalign_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: reset, handshake timing, next-PC modes, stalls and async reset.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [15:0] imm16;
  logic [31:0] pc;
  logic [1:0]  npc_op;
  logic        br_taken;
  logic [31:0] imm_ext;
  logic [25:0] j_index;
  logic [31:0] jr_target;
  logic        misalign;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  ifu_fetch #(.RESET_PC(32'h0000_3000)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .imm16       (imm16),
    .pc          (pc),
    .npc_op      (npc_op),
    .br_taken    (br_taken),
    .imm_ext     (imm_ext),
    .j_index     (j_index),
    .jr_target   (jr_target),
    .misalign    (misalign)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Enter HOLD from FETCH with a same-cycle ack.
  task automatic fetch(input logic [31:0] word);
    imem_ack   = 1'b1;
    imem_rdata = word;
    step();
    imem_ack = 1'b0;
    check("fetch_valid", {31'b0, instr_valid}, 32'd1);
    check("fetch_instr", instr, word);
    check("fetch_imm16", {16'b0, imm16}, {16'b0, word[15:0]});
  endtask

  // Accept the held instruction with the given next-PC controls.
  task automatic retire(input string tag, input logic [1:0] op, input logic br,
                        input logic [31:0] imm, input logic [25:0] jidx,
                        input logic [31:0] jr, input logic [31:0] exp_pc);
    npc_op      = op;
    br_taken    = br;
    imm_ext     = imm;
    j_index     = jidx;
    jr_target   = jr;
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    check(tag, pc, exp_pc);
    check({tag, "_req"}, {31'b0, imem_req}, 32'd1);
    check({tag, "_addr"}, imem_addr, exp_pc);
  endtask

  initial begin
    reset       = 1'b1;
    imem_ack    = 1'b0;
    imem_rdata  = 32'h0;
    instr_ready = 1'b0;
    npc_op      = 2'b00;
    br_taken    = 1'b0;
    imm_ext     = 32'h0;
    j_index     = 26'h0;
    jr_target   = 32'h0;

    step();
    step();
    check("rst_pc", pc, 32'h0000_3000);
    check("rst_instr", instr, 32'h0);
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_misalign", {31'b0, misalign}, 32'd0);

    reset = 1'b0;
    step();
    check("first_req", {31'b0, imem_req}, 32'd1);
    check("first_addr", imem_addr, 32'h0000_3000);
    fetch(32'h1234_ABCD);
    check("hold_req_low", {31'b0, imem_req}, 32'd0);

    // Sequential, then ack delayed by three cycles.
    retire("seq_pc", 2'b00, 1'b0, 32'h0, 26'h0, 32'h0, 32'h0000_3004);
    for (int i = 0; i < 3; i++) begin
      step();
      check("wait_req", {31'b0, imem_req}, 32'd1);
      check("wait_addr", imem_addr, 32'h0000_3004);
    end
    fetch(32'h0800_0C04);

    retire("j_to_3010", 2'b10, 1'b0, 32'h0, 26'h000_0C04, 32'h0, 32'h0000_3010);
    fetch(32'h1000_FFFE);
    retire("br_taken", 2'b01, 1'b1, 32'hFFFF_FFF8, 26'h0, 32'h0, 32'h0000_300C);
    fetch(32'h0000_0000);
    retire("seq_to_3010", 2'b00, 1'b0, 32'h0, 26'h0, 32'h0, 32'h0000_3010);
    fetch(32'h1000_FFFE);
    retire("br_not_taken", 2'b01, 1'b0, 32'hFFFF_FFF8, 26'h0, 32'h0, 32'h0000_3014);
    fetch(32'h0000_0008);
    retire("jr_aligned", 2'b11, 1'b0, 32'h0, 26'h0, 32'h0000_3000, 32'h0000_3000);
    check("jr_aligned_mis", {31'b0, misalign}, 32'd0);
    fetch(32'h0800_0C10);
    retire("j_to_3040", 2'b10, 1'b0, 32'h0, 26'h000_0C10, 32'h0, 32'h0000_3040);
    fetch(32'h0000_0008);
    retire("jr_misaligned", 2'b11, 1'b0, 32'h0, 26'h0, 32'h0000_3102, 32'h0000_3100);
    check("mis_pulse", {31'b0, misalign}, 32'd1);
    step();
    check("mis_clear", {31'b0, misalign}, 32'd0);
    check("mis_pc_stable", pc, 32'h0000_3100);

    // Stall in HOLD with a stray ack pulse.
    fetch(32'hDEAD_0001);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        imem_ack   = 1'b1;
        imem_rdata = 32'hCAFE_F00D;
      end else begin
        imem_ack = 1'b0;
      end
      step();
      check("stall_instr", instr, 32'hDEAD_0001);
      check("stall_pc", pc, 32'h0000_3100);
      check("stall_valid", {31'b0, instr_valid}, 32'd1);
    end
    imem_ack = 1'b0;
    retire("post_stall", 2'b00, 1'b0, 32'h0, 26'h0, 32'h0, 32'h0000_3104);

    // Async reset mid-FETCH while ack is high.
    imem_ack   = 1'b1;
    imem_rdata = 32'hBEEF_BEEF;
    reset      = 1'b1;
    #1;
    check("arst_req", {31'b0, imem_req}, 32'd0);
    check("arst_valid", {31'b0, instr_valid}, 32'd0);
    step();
    check("arst_instr", instr, 32'h0);
    check("arst_pc", pc, 32'h0000_3000);
    imem_ack = 1'b0;
    reset    = 1'b0;
    step();
    check("refetch_req", {31'b0, imem_req}, 32'd1);
    check("refetch_addr", imem_addr, 32'h0000_3000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
